digit_scan_driver: RTL and testbench
====================================

# digit_scan_driver

Downstream display stage for the two-digit seconds timer: takes the timer's tens and ones BCD digits and the Time_Out flag, and time-multiplexes them onto the single seg7 decoder plus two digit-enable lines. It replaces manual digit selection with a free-running scan. It adds:
- anti-ghosting dead slots,
- frame-coherent digit snapshots,
- optional leading-zero blanking,
- a blink effect while Time_Out is high.

## Interface
Parameters:
- SCAN_DIV, 24'd5000: clock cycles per live digit slot; legal range ≥ 1.
- DEAD_CYCLES, 4'd2: blank cycles before each live slot; legal range ≥ 1.
- BLINK_DIV, 24'd5_000_000: clock cycles per blink half-period; legal range ≥ 1.

Ports:
- Clock, input, 1: system clock.
- Reset, input, 1: synchronous, active-high reset.
- Enable, input, 1: scan enable. Registered internally.
- Tens, input, 4: BCD tens digit from the timer.
- Ones, input, 4: BCD ones digit from the timer.
- Time_Out, input, 1: timer-expired flag. Enables blinking.
- Blank_Lead, input, 1: when 1, suppress a leading zero in the tens slot.
- Digit, output, 4: BCD value fed to seg7.
- Blank, output, 1: 1 means segments must be off.
- Dig_Sel, output, 2: one-hot, active-high digit enable. 01 = ones, 10 = tens.
- Frame_Tick, output, 1: one-cycle pulse at the start of each frame.

## Operation
- FSM states: ONES_DEAD → ONES → TENS_DEAD → TENS → ONES_DEAD.
  - Reset state is ONES_DEAD with slot counter 0.
  - Dead states last DEAD_CYCLES cycles; live states last SCAN_DIV cycles.
  - The slot counter clears on every state change.
- Snapshot: Tens/Ones are loaded into snap_tens/snap_ones on the first cycle of ONES_DEAD (slot counter 0), including the first cycle after reset.
  - Input changes later in the frame are not displayed until the next frame.
  - Reset clears both snapshots to 0.
- Outputs are Moore outputs, decoded from registers only; there is no combinational path from inputs to outputs.
  - Dead states: Dig_Sel=00, Blank=1, Digit=0.
  - ONES: Digit=snap_ones, Dig_Sel=01.
  - TENS: Digit=snap_tens, Dig_Sel=10.
- A live slot is suppressed when any of the following holds:
  - the snapshot digit is > 9;
  - it is the TENS slot, Blank_Lead is registered 1, and snap_tens=0;
  - the blink phase is 1;
  - the registered Enable is 0.
- A suppressed slot outputs Dig_Sel=00, Blank=1, Digit=0.
- Invariant: Blank=1 exactly when Dig_Sel=00.
- Blink:
  - While Time_Out=1, the blink counter counts to BLINK_DIV-1, wraps to 0, and toggles the phase.
  - While Time_Out=0, the counter and phase clear at the next edge, so the display is visible.
  - The blink counter is independent of the scan FSM.
- Enable: when registered Enable=0, the FSM, slot counter and blink counter hold, and outputs are suppressed. Scanning resumes from the held position.
- Frame_Tick is 1 on the cycle the snapshot loads, i.e. ONES_DEAD with counter 0. It is also 1 on the first cycle after reset, but only if Enable is registered 1.

## Timing
- Reset values: Digit=0, Blank=1, Dig_Sel=00, Frame_Tick=0. All counters, phase, snapshots and the registered Enable/Blank_Lead are 0.
- Reset asserted mid-frame: reset values appear at the next edge. The FSM restarts in ONES_DEAD.
- Frame period is 2·(SCAN_DIV+DEAD_CYCLES) cycles. Each digit's duty cycle is SCAN_DIV/period.
- Input latency:
  - Enable and Blank_Lead take effect on outputs 1 cycle after sampling.
  - Tens/Ones take effect at the next snapshot load.
  - Time_Out deassertion makes the display visible within 1 cycle.
- Counter widths: 24-bit scan and blink counters. Terminal count uses equality with DIV-1; there is no overflow path.

## Structure
- Shared package `scan_pkg` holds:
  - state encoding constants ST_ONES_DEAD, ST_ONES, ST_TENS_DEAD, ST_TENS;
  - DIG_ONES=2'b01 and DIG_TENS=2'b10;
  - DIG_OFF=2'b00;
  - BCD_MAX=4'd9.
- One sub-module, `tc_counter`: parameterised terminal-count counter with clear/enable and a wrap pulse. Instantiate it twice, once for the slot counter and once for the blink counter.

## Test plan
All scenarios use SCAN_DIV=4, DEAD_CYCLES=1, BLINK_DIV=8, with Enable=1 unless stated.
- Reset high for 3 cycles, then released:
  - During reset, outputs hold reset values.
  - After release, Dig_Sel repeats 00×1, 01×4, 00×1, 10×4 with a period of 10.
  - Frame_Tick pulses every 10 cycles.
- Tens=4, Ones=7: Digit=7 while Dig_Sel=01 and Digit=4 while Dig_Sel=10. Blank=0 in live slots.
- Ones changes 7→2 during the ONES slot: Digit stays 7 for the rest of the frame and becomes 2 only after the next Frame_Tick.
- Leading zero, Tens=0:
  - Blank_Lead=1: the tens slot shows Dig_Sel=00, Blank=1.
  - Blank_Lead=0: the tens slot shows Digit=0, Dig_Sel=10.
  - Ones=4'hC: the ones slot is suppressed.
- Blink, Time_Out=1:
  - Outputs follow the normal scan for 8 cycles, then are fully suppressed for 8 cycles, alternating.
  - Dropping Time_Out during the suppressed phase restores visibility on the next cycle.
- Enable and mid-frame reset:
  - Enable=0 mid-TENS: outputs go 00/Blank from the next cycle and the counter holds. Re-enabling completes the remaining TENS cycles.
  - Reset pulsed mid-TENS: reset values next cycle, then the sequence restarts at 00×1.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared encodings for the two-digit display scanner: slot states, digit-enable
// codes and the largest displayable BCD value.
package scan_pkg;

  localparam int CNT_W = 24;

  typedef enum logic [1:0] {
    ST_ONES_DEAD = 2'd0,
    ST_ONES      = 2'd1,
    ST_TENS_DEAD = 2'd2,
    ST_TENS      = 2'd3
  } scan_state_t;

  localparam logic [1:0] DIG_OFF  = 2'b00;
  localparam logic [1:0] DIG_ONES = 2'b01;
  localparam logic [1:0] DIG_TENS = 2'b10;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic scan_state_t next_slot(input scan_state_t s);
    case (s)
      ST_ONES_DEAD: return ST_ONES;
      ST_ONES:      return ST_TENS_DEAD;
      ST_TENS_DEAD: return ST_TENS;
      default:      return ST_ONES_DEAD;
    endcase
  endfunction

  function automatic logic is_dead(input scan_state_t s);
    return (s == ST_ONES_DEAD) || (s == ST_TENS_DEAD);
  endfunction

endpackage

// File: rtl/digit_scan_driver_tc_counter.sv
// Terminal-count counter: counts while enabled, wraps to 0 after reaching term
// and flags that cycle with a wrap pulse. Clear and reset force it to 0.
module tc_counter #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  assign wrap = en && (count == term);

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/digit_scan_driver.sv
// Time-multiplexes a two-digit BCD timer onto one seg7 decoder with dead slots,
// per-frame digit snapshots, leading-zero blanking and a Time_Out blink.
module digit_scan_driver
  import scan_pkg::*;
#(
  parameter logic [23:0] SCAN_DIV    = 24'd5000,
  parameter logic [3:0]  DEAD_CYCLES = 4'd2,
  parameter logic [23:0] BLINK_DIV   = 24'd5_000_000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic [3:0] Tens,
  input  logic [3:0] Ones,
  input  logic       Time_Out,
  input  logic       Blank_Lead,
  output logic [3:0] Digit,
  output logic       Blank,
  output logic [1:0] Dig_Sel,
  output logic       Frame_Tick
);

  localparam logic [CNT_W-1:0] SCAN_LAST  = SCAN_DIV - 24'd1;
  localparam logic [CNT_W-1:0] DEAD_LAST  = {20'd0, DEAD_CYCLES} - 24'd1;
  localparam logic [CNT_W-1:0] BLINK_LAST = BLINK_DIV - 24'd1;

  scan_state_t      state;
  logic             en_r;
  logic             bl_r;
  logic [3:0]       snap_tens;
  logic [3:0]       snap_ones;
  logic             phase;

  logic [CNT_W-1:0] slot_cnt;
  logic [CNT_W-1:0] slot_term;
  logic             slot_wrap;
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_wrap;
  logic             frame_start;

  assign slot_term   = is_dead(state) ? DEAD_LAST : SCAN_LAST;
  assign frame_start = en_r && (state == ST_ONES_DEAD) && (slot_cnt == '0);

  // Each slot ends exactly on a wrap, so the wrap itself clears the counter.
  tc_counter #(.WIDTH(CNT_W)) u_slot_cnt (
    .clk   (Clock),
    .rst   (Reset),
    .clr   (1'b0),
    .en    (en_r),
    .term  (slot_term),
    .count (slot_cnt),
    .wrap  (slot_wrap)
  );

  tc_counter #(.WIDTH(CNT_W)) u_blink_cnt (
    .clk   (Clock),
    .rst   (Reset),
    .clr   (!Time_Out),
    .en    (en_r && Time_Out),
    .term  (BLINK_LAST),
    .count (blink_cnt),
    .wrap  (blink_wrap)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= ST_ONES_DEAD;
      en_r      <= 1'b0;
      bl_r      <= 1'b0;
      snap_tens <= 4'd0;
      snap_ones <= 4'd0;
      phase     <= 1'b0;
    end else begin
      en_r <= Enable;
      bl_r <= Blank_Lead;
      if (frame_start) begin
        snap_tens <= Tens;
        snap_ones <= Ones;
      end
      if (slot_wrap) begin
        state <= next_slot(state);
      end
      if (!Time_Out) begin
        phase <= 1'b0;
      end else if (blink_wrap) begin
        phase <= ~phase;
      end
    end
  end

  // Moore decode from registers only; every suppressed case falls through to blank.
  always_comb begin
    // NOTE: defaults first so no branch leaves an output unassigned (no latch).
    Digit   = 4'd0;
    Blank   = 1'b1;
    Dig_Sel = DIG_OFF;
    if (en_r && !phase) begin
      case (state)
        ST_ONES: begin
          if (snap_ones <= BCD_MAX) begin
            Digit   = snap_ones;
            Blank   = 1'b0;
            Dig_Sel = DIG_ONES;
          end
        end
        ST_TENS: begin
          if ((snap_tens <= BCD_MAX) && !(bl_r && (snap_tens == 4'd0))) begin
            Digit   = snap_tens;
            Blank   = 1'b0;
            Dig_Sel = DIG_TENS;
          end
        end
        default: ;
      endcase
    end
  end

  assign Frame_Tick = frame_start;

endmodule

// File: tb/tb_digit_scan_driver.sv
// Self-checking bench for digit_scan_driver: directed scenarios followed by a
// randomized run, all compared each cycle against a frame-position model.
module tb_digit_scan_driver;

  localparam int S = 4;
  localparam int D = 1;
  localparam int B = 8;
  localparam int P = 2 * (S + D);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       time_out = 1'b0;
  logic       blank_lead = 1'b0;
  logic [3:0] tens = 4'd0;
  logic [3:0] ones = 4'd0;

  logic [3:0] digit;
  logic       blank;
  logic [1:0] dig_sel;
  logic       frame_tick;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  digit_scan_driver #(
    .SCAN_DIV    (24'd4),
    .DEAD_CYCLES (4'd1),
    .BLINK_DIV   (24'd8)
  ) dut (
    .Clock      (clk),
    .Reset      (rst),
    .Enable     (enable),
    .Tens       (tens),
    .Ones       (ones),
    .Time_Out   (time_out),
    .Blank_Lead (blank_lead),
    .Digit      (digit),
    .Blank      (blank),
    .Dig_Sel    (dig_sel),
    .Frame_Tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: position within the frame (0..P-1) plus the number of
  // enabled Time_Out edges, from which the blink phase follows arithmetically.
  int         m_pos = 0;
  int         m_bn  = 0;
  logic       m_en  = 1'b0;
  logic       m_bl  = 1'b0;
  logic [3:0] m_t   = 4'd0;
  logic [3:0] m_o   = 4'd0;

  always @(posedge clk) begin
    if (rst) begin
      m_pos <= 0;
      m_bn  <= 0;
      m_en  <= 1'b0;
      m_bl  <= 1'b0;
      m_t   <= 4'd0;
      m_o   <= 4'd0;
    end else begin
      if (m_en && m_pos == 0) begin
        m_t <= tens;
        m_o <= ones;
      end
      if (!time_out) m_bn <= 0;
      else if (m_en) m_bn <= (m_bn + 1) % (2 * B);
      if (m_en) m_pos <= (m_pos + 1) % P;
      m_en <= enable;
      m_bl <= blank_lead;
    end
  end

  // {digit, blank, dig_sel, frame_tick}
  function automatic logic [7:0] model_out();
    logic [3:0] d   = 4'd0;
    logic       bk  = 1'b1;
    logic [1:0] sl  = 2'b00;
    bit         vis = m_en && (m_bn < B);
    if (vis && m_pos >= D && m_pos < D + S && m_o <= 4'd9) begin
      d = m_o; bk = 1'b0; sl = 2'b01;
    end else if (vis && m_pos >= 2 * D + S && m_t <= 4'd9 && !(m_bl && m_t == 4'd0)) begin
      d = m_t; bk = 1'b0; sl = 2'b10;
    end
    return {d, bk, sl, (m_en && m_pos == 0)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then compare every output against the model at negedge.
  task automatic cycle();
    logic [7:0] e;
    @(negedge clk);
    e = model_out();
    check("digit",      32'(digit),      32'(e[7:4]));
    check("blank",      32'(blank),      32'(e[3]));
    check("dig_sel",    32'(dig_sel),    32'(e[2:1]));
    check("frame_tick", 32'(frame_tick), 32'(e[0]));
    check("blank_inv",  32'(blank),      32'(dig_sel == 2'b00));
  endtask

  task automatic wait_sel(input logic [1:0] want, input int budget);
    int k = 0;
    while (dig_sel !== want && k < budget) begin
      cycle();
      k++;
    end
    check("wait_sel", 32'(dig_sel), 32'(want));
  endtask

  task automatic wait_tick(input int budget);
    int k = 0;
    while (frame_tick !== 1'b1 && k < budget) begin
      cycle();
      k++;
    end
    check("wait_tick", 32'(frame_tick), 32'd1);
  endtask

  task automatic count_sel(input int cycles, input logic [1:0] want, output int hits);
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      cycle();
      if (dig_sel === want) hits++;
    end
  endtask

  initial begin
    int hits;
    int ticks;

    // Reset held for three edges.
    rst = 1'b1; enable = 1'b1; tens = 4'd4; ones = 4'd7;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("rst_digit", 32'(digit),      32'd0);
      check("rst_blank", 32'(blank),      32'd1);
      check("rst_sel",   32'(dig_sel),    32'd0);
      check("rst_tick",  32'(frame_tick), 32'd0);
    end
    rst = 1'b0;

    // Free-running scan: two frames of 10 cycles.
    ticks = 0; hits = 0;
    for (int i = 0; i < 2 * P; i++) begin
      cycle();
      if (frame_tick === 1'b1) ticks++;
      if (dig_sel === 2'b01) hits++;
    end
    check("tick_count", 32'(ticks), 32'd2);
    check("ones_slots", 32'(hits),  32'd8);

    // Ones changes inside the ONES slot: old snapshot persists to frame end.
    wait_sel(2'b01, 2 * P);
    ones = 4'd2;
    cycle();
    check("snap_hold", 32'(digit), 32'd7);
    wait_tick(2 * P);
    wait_sel(2'b01, 2 * P);
    check("snap_new", 32'(digit), 32'd2);

    // Leading zero with and without blanking, then an invalid ones digit.
    tens = 4'd0; ones = 4'd5; blank_lead = 1'b1;
    for (int i = 0; i < P + 2; i++) cycle();
    count_sel(P, 2'b10, hits);
    check("lead_blanked", 32'(hits), 32'd0);
    blank_lead = 1'b0;
    for (int i = 0; i < P + 2; i++) cycle();
    count_sel(P, 2'b10, hits);
    check("lead_shown", 32'(hits), 32'd4);
    ones = 4'hC;
    for (int i = 0; i < P + 2; i++) cycle();
    count_sel(P, 2'b01, hits);
    check("ones_invalid", 32'(hits), 32'd0);

    // Blink: eight visible, then dark; dropping Time_Out restores at once.
    tens = 4'd4; ones = 4'd7;
    for (int i = 0; i < P + 2; i++) cycle();
    time_out = 1'b1;
    for (int i = 0; i < B - 1; i++) cycle();
    count_sel(4, 2'b00, hits);
    check("blink_dark", 32'(hits), 32'd4);
    time_out = 1'b0;
    count_sel(P, 2'b00, hits);
    check("blink_restore_off", 32'(hits), 32'd2);

    // Enable dropped mid-TENS: held position resumes on re-enable.
    wait_sel(2'b10, 2 * P);
    cycle();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    check("disabled_sel", 32'(dig_sel), 32'd0);
    enable = 1'b1;
    count_sel(6, 2'b10, hits);
    check("tens_resume", 32'(hits), 32'd2);

    // Reset pulsed mid-TENS.
    wait_sel(2'b10, 2 * P);
    rst = 1'b1;
    cycle();
    check("midrst_sel",  32'(dig_sel), 32'd0);
    check("midrst_blank", 32'(blank),  32'd1);
    rst = 1'b0;
    cycle();
    check("restart_tick", 32'(frame_tick), 32'd1);
    for (int i = 0; i < P; i++) cycle();

    // Randomized run against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 8)  tens = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 99) < 8)  ones = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 99) < 5)  blank_lead = ~blank_lead;
      if ($urandom_range(0, 99) < 3)  time_out = ~time_out;
      enable = ($urandom_range(0, 99) >= 10);
      rst    = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
